// File: rtl/sprite_plotter.sv
// Cursor position and sprite rasteriser between the etch-a-sketch controller and the VGA adapter.
// Optional per-pixel transparency mask is enabled by defining SPRITE_MASK_EN.
module sprite_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int STEP     = 1,
  parameter int X_INIT   = 78,
  parameter int Y_INIT   = 58
`ifdef SPRITE_MASK_EN
  ,
  parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = '1
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pos_en,
  input  logic           plot_en,
  input  logic           dir_up,
  input  logic           dir_down,
  input  logic           dir_left,
  input  logic           dir_right,
  input  logic [2:0]     colour_in,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done
);

  localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(SPRITE_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(SPRITE_H - 1);
  localparam logic [X_W:0]   X_LIM   = (X_W+1)'(X_MAX - SPRITE_W + 1);
  localparam logic [Y_W:0]   Y_LIM   = (Y_W+1)'(Y_MAX - SPRITE_H + 1);
  localparam logic [X_W:0]   X_STP   = (X_W+1)'(STEP);
  localparam logic [Y_W:0]   Y_STP   = (Y_W+1)'(STEP);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  state_t         r_state, w_state_next;
  logic [X_W-1:0] r_pos_x, r_base_x, r_vga_x;
  logic [Y_W-1:0] r_pos_y, r_vga_y;
  logic [CXW-1:0] r_cx;
  logic [CYW-1:0] r_cy;
  logic [2:0]     r_vga_colour;
  logic           r_vga_plot, r_busy, r_done;

  logic [X_W-1:0] w_pos_x_n, w_base_x_n, w_vga_x_n, w_x_move, w_x_next;
  logic [Y_W-1:0] w_pos_y_n, w_vga_y_n, w_y_move, w_y_next;
  logic [CXW-1:0] w_cx_n;
  logic [CYW-1:0] w_cy_n;
  logic [2:0]     w_vga_colour_n;
  logic           w_vga_plot_n, w_last, w_first_on, w_step_on;
  logic [X_W:0]   w_x_inc;
  logic [Y_W:0]   w_y_inc;

  assign w_last  = (r_cx == CX_LAST) && (r_cy == CY_LAST);
  assign w_x_inc = {1'b0, r_pos_x} + X_STP;
  assign w_y_inc = {1'b0, r_pos_y} + Y_STP;

`ifdef SPRITE_MASK_EN
  localparam int IDXW = (SPRITE_W*SPRITE_H > 1) ? $clog2(SPRITE_W*SPRITE_H) : 1;
  logic [IDXW-1:0] w_idx, w_idx_inc;
  // Mask bit is looked up one pixel ahead so vga_plot stays registered.
  assign w_idx      = IDXW'(int'(r_cy) * SPRITE_W + int'(r_cx));
  assign w_idx_inc  = w_idx + 1'b1;
  assign w_first_on = SPRITE_MASK[0];
  assign w_step_on  = SPRITE_MASK[w_idx_inc];
`else
  assign w_first_on = 1'b1;
  assign w_step_on  = 1'b1;
`endif

  // Clamped move; opposing or absent directions leave the axis unchanged.
  always_comb begin
    w_x_move = r_pos_x;
    w_y_move = r_pos_y;
    if (dir_right && !dir_left)
      w_x_move = (w_x_inc > X_LIM) ? X_LIM[X_W-1:0] : w_x_inc[X_W-1:0];
    else if (dir_left && !dir_right)
      w_x_move = ({1'b0, r_pos_x} < X_STP) ? '0 : r_pos_x - X_STP[X_W-1:0];
    if (dir_down && !dir_up)
      w_y_move = (w_y_inc > Y_LIM) ? Y_LIM[Y_W-1:0] : w_y_inc[Y_W-1:0];
    else if (dir_up && !dir_down)
      w_y_move = ({1'b0, r_pos_y} < Y_STP) ? '0 : r_pos_y - Y_STP[Y_W-1:0];
    w_x_next = pos_en ? w_x_move : r_pos_x;
    w_y_next = pos_en ? w_y_move : r_pos_y;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (plot_en) w_state_next = DRAW;
      DRAW:    if (w_last)  w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_pos_x_n      = r_pos_x;
    w_pos_y_n      = r_pos_y;
    w_base_x_n     = r_base_x;
    w_vga_x_n      = r_vga_x;
    w_vga_y_n      = r_vga_y;
    w_vga_colour_n = r_vga_colour;
    w_cx_n         = r_cx;
    w_cy_n         = r_cy;
    w_vga_plot_n   = 1'b0;
    case (r_state)
      IDLE: begin
        w_pos_x_n = w_x_next;
        w_pos_y_n = w_y_next;
        if (plot_en) begin
          w_base_x_n     = w_x_next;
          w_vga_x_n      = w_x_next;
          w_vga_y_n      = w_y_next;
          w_vga_colour_n = colour_in;
          w_cx_n         = '0;
          w_cy_n         = '0;
          w_vga_plot_n   = w_first_on;
        end
      end
      DRAW: begin
        if (!w_last) begin
          w_vga_plot_n = w_step_on;
          if (r_cx == CX_LAST) begin
            w_cx_n    = '0;
            w_cy_n    = r_cy + 1'b1;
            w_vga_x_n = r_base_x;
            w_vga_y_n = r_vga_y + 1'b1;
          end else begin
            w_cx_n    = r_cx + 1'b1;
            w_vga_x_n = r_vga_x + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos_x      <= X_W'(X_INIT);
      r_pos_y      <= Y_W'(Y_INIT);
      r_base_x     <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pos_x      <= w_pos_x_n;
      r_pos_y      <= w_pos_y_n;
      r_base_x     <= w_base_x_n;
      r_vga_x      <= w_vga_x_n;
      r_vga_y      <= w_vga_y_n;
      r_vga_colour <= w_vga_colour_n;
      r_cx         <= w_cx_n;
      r_cy         <= w_cy_n;
      r_vga_plot   <= w_vga_plot_n;
      r_busy       <= (w_state_next != IDLE);
      r_done       <= (w_state_next == FIN);
    end
  end

  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// Randomised and directed bench for sprite_plotter against a cycle-level behavioural model.
module tb_sprite_plotter;
  localparam int X_W = 8, Y_W = 7, SW = 4, SH = 4, N = SW * SH;
  localparam int X_INIT = 78, Y_INIT = 58, STEP = 1;
  localparam int X_HI = 159 - SW + 1, Y_HI = 119 - SH + 1;
`ifdef SPRITE_MASK_EN
  localparam logic [N-1:0] MASK = 16'h8001;
`else
  localparam logic [N-1:0] MASK = '1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, pos_en = 1'b0, plot_en = 1'b0;
  logic dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
  logic [2:0] colour_in = '0;
  logic [X_W-1:0] pos_x, vga_x;
  logic [Y_W-1:0] pos_y, vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, busy, done;

  sprite_plotter #(
    .X_W(X_W), .Y_W(Y_W), .SPRITE_W(SW), .SPRITE_H(SH)
`ifdef SPRITE_MASK_EN
    , .SPRITE_MASK(MASK)
`endif
  ) dut (
    .clk(clk), .reset(reset), .pos_en(pos_en), .plot_en(plot_en),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .colour_in(colour_in), .pos_x(pos_x), .pos_y(pos_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int m_x, m_y, m_cnt, m_bx, m_by, m_col, writes;
  bit m_rst;
  logic [N-1:0] mask_v = MASK;

  task automatic chk(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  function automatic int clampv(input int v, input bit inc, input bit dec, input int hi);
    int nv = v;
    if (inc && !dec) nv = v + STEP;
    if (dec && !inc) nv = v - STEP;
    if (nv < 0) nv = 0;
    if (nv > hi) nv = hi;
    return nv;
  endfunction

  // m_cnt counts cycles left busy: N+1 after an accepted plot, 1 means the done cycle.
  task automatic tick(input bit r, input bit pe, input bit pl, input bit u, input bit d,
                      input bit l, input bit rt, input logic [2:0] c);
    int i;
    reset = r; pos_en = pe; plot_en = pl;
    dir_up = u; dir_down = d; dir_left = l; dir_right = rt; colour_in = c;
    @(posedge clk);
    m_rst = r;
    if (r) begin
      m_x = X_INIT; m_y = Y_INIT; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else begin
      if (pe) begin
        m_x = clampv(m_x, rt, l, X_HI);
        m_y = clampv(m_y, d, u, Y_HI);
      end
      if (pl) begin
        m_bx = m_x; m_by = m_y; m_col = int'(c); m_cnt = N + 1;
      end
    end
    #1;
    if (vga_plot) writes++;
    chk("pos_x", int'(pos_x), m_x);
    chk("pos_y", int'(pos_y), m_y);
    chk("busy", int'(busy), int'(m_cnt > 0));
    chk("done", int'(done), int'(m_cnt == 1));
    if (m_cnt > 1) begin
      i = N + 1 - m_cnt;
      chk("vga_plot", int'(vga_plot), int'(mask_v[i]));
      chk("vga_x", int'(vga_x), m_bx + i % SW);
      chk("vga_y", int'(vga_y), m_by + i / SW);
      chk("vga_colour", int'(vga_colour), m_col);
    end else begin
      chk("vga_plot_idle", int'(vga_plot), 0);
    end
    if (m_rst) begin
      chk("rst_vga_x", int'(vga_x), 0);
      chk("rst_vga_y", int'(vga_y), 0);
      chk("rst_colour", int'(vga_colour), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0, 3'd0);
  endtask

  task automatic move(input int n, input bit u, input bit d, input bit l, input bit rt);
    for (int k = 0; k < n; k++) tick(0, 1, 0, u, d, l, rt, 3'd0);
  endtask

  initial begin
    m_x = X_INIT; m_y = Y_INIT; m_cnt = 0; m_bx = 0; m_by = 0; m_col = 0; writes = 0;
    tick(1, 0, 0, 0, 0, 0, 0, 3'd0);
    tick(1, 0, 0, 0, 0, 0, 0, 3'd0);
    idle(5);
    chk("reset_pos_x", int'(pos_x), 78);
    chk("reset_pos_y", int'(pos_y), 58);

    move(1, 0, 0, 0, 1);
    chk("right_once", int'(pos_x), 79);
    move(1, 1, 0, 0, 0);
    chk("up_once_y", int'(pos_y), 57);
    chk("up_once_x", int'(pos_x), 79);

    move(200, 0, 0, 0, 1);
    chk("sat_right", int'(pos_x), 156);
    move(200, 0, 0, 1, 0);
    chk("sat_left", int'(pos_x), 0);
    move(3, 0, 0, 0, 1);
    move(2, 0, 0, 1, 1);
    chk("left_right", int'(pos_x), 3);
    move(200, 1, 0, 0, 0);
    chk("sat_up", int'(pos_y), 0);
    move(200, 0, 1, 0, 0);
    chk("sat_down", int'(pos_y), 116);

    move(7, 0, 0, 0, 1);
    move(96, 1, 0, 0, 0);
    chk("at_x10", int'(pos_x), 10);
    chk("at_y20", int'(pos_y), 20);
    writes = 0;
    tick(0, 0, 1, 0, 0, 0, 0, 3'b101);
    idle(20);
    chk("writes_draw", writes, $countones(MASK));

    // Requests while busy must be dropped.
    writes = 0;
    tick(0, 0, 1, 0, 0, 0, 0, 3'b011);
    for (int k = 0; k < N + 1; k++) tick(0, 1, 1, 0, 1, 0, 1, 3'b110);
    idle(3);
    chk("writes_busy", writes, $countones(MASK));
    chk("busy_pos_x", int'(pos_x), 10);
    chk("busy_pos_y", int'(pos_y), 20);

    tick(0, 1, 1, 0, 1, 0, 0, 3'b010);
    chk("plot_new_y", int'(vga_y), 21);
    idle(N + 3);

    tick(0, 0, 1, 0, 0, 0, 0, 3'b111);
    idle(4);
    tick(1, 0, 0, 0, 0, 0, 0, 3'd0);
    writes = 0;
    idle(N + 3);
    chk("abort_writes", writes, 0);

    for (int k = 0; k < 600; k++)
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 12) == 0,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    idle(N + 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
Datapath responder to the etch-a-sketch control FSM.
- On a pos_en pulse: moves the cursor position from the direction inputs, with edge clamping.
- On a plot_en pulse: rasterises a SPRITE_W x SPRITE_H sprite at the cursor, one pixel per cycle, into the VGA adapter write port.
- Sits between the controller and the VGA adapter; provides busy/done status for the controller.

Parameters:
- X_W, 8, width of the x coordinate.
- Y_W, 7, width of the y coordinate.
- X_MAX, 159, last visible column.
- Y_MAX, 119, last visible row.
- SPRITE_W, 4, sprite width in pixels (power of two, at least 1).
- SPRITE_H, 4, sprite height in pixels (power of two, at least 1).
- STEP, 1, pixels moved per pos_en.
- X_INIT, 78, reset x of the sprite top-left corner.
- Y_INIT, 58, reset y of the sprite top-left corner.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pos_en  in  1  single-cycle request to update the position.
- plot_en  in  1  single-cycle request to draw the sprite.
- dir_up, dir_down, dir_left, dir_right  in  1 each  movement direction, level inputs.
- colour_in  in  3  sprite colour, sampled on plot_en.
- pos_x  out  X_W  current top-left x.
- pos_y  out  Y_W  current top-left y.
- vga_x  out  X_W  pixel x to the VGA adapter.
- vga_y  out  Y_W  pixel y to the VGA adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  VGA write enable.
- busy  out  1  high while drawing or completing.
- done  out  1  one-cycle pulse when a draw completes.

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - pos_x=X_INIT, pos_y=Y_INIT.
  - vga_x, vga_y, vga_colour = 0; vga_plot=0, busy=0, done=0.
  - State goes to IDLE.
- Reset asserted mid-draw aborts the draw: no further vga_plot, no done pulse.
- States: IDLE, DRAW, FIN.
- IDLE:
  - pos_en=1: x_next and y_next are computed, and pos_x/pos_y are updated at this edge.
    - dir_right alone: x+STEP, saturating at X_MAX-SPRITE_W+1.
    - dir_left alone: x-STEP, saturating at 0 (no unsigned wrap).
    - dir_left and dir_right together, or neither: x unchanged.
    - dir_down, dir_up and y use the same rules, with limit Y_MAX-SPRITE_H+1.
  - plot_en=1:
    - Snapshot base_x/base_y and colour_in; clear cx and cy; go to DRAW.
    - If pos_en is also high in the same cycle, the snapshot uses the updated x_next/y_next.
- DRAW:
  - Every cycle: vga_plot=1, vga_x=base_x+cx, vga_y=base_y+cy, vga_colour=latched colour.
  - cx increments each cycle. On cx=SPRITE_W-1, cx wraps to 0 and cy increments.
  - After pixel (SPRITE_W-1, SPRITE_H-1), go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Timing: if plot_en is sampled at edge k, vga_plot is high for cycles k+1 .. k+N (N = SPRITE_W*SPRITE_H, 16 by default), and done is high in cycle k+N+1.
- busy = state is DRAW or FIN. busy is high for cycles k+1 .. k+N+1.
- While busy, pos_en and plot_en are ignored: no position change, no queued draw.
- All outputs are registered; no combinational path from inputs to outputs.
- Pixel addresses never exceed X_MAX/Y_MAX, because the clamp keeps the sprite fully on screen.

Optional Feature:
- Macro: SPRITE_MASK_EN.
- Defined:
  - Adds parameter SPRITE_MASK, SPRITE_W*SPRITE_H bits, default all ones. Bit index = cy*SPRITE_W+cx.
  - In DRAW, vga_plot = SPRITE_MASK[index]. vga_x/vga_y still advance every cycle.
  - DRAW length and done/busy timing are unchanged, so a mask of 0 gives N cycles with no writes.
- Undefined: solid rectangle; vga_plot=1 for every DRAW cycle.

Test Plan:
- Reset then idle 5 cycles -> pos=(78,58); vga_plot=0, busy=0, done=0.
- pos_en with dir_right=1, then pos_en with dir_up=1 -> pos=(79,58), then (79,57).
- Apply 200 pos_en pulses with dir_right=1 -> pos_x saturates at 156. Then 200 with dir_left=1 -> pos_x=0 with no wrap. Left and right together -> x unchanged.
- plot_en with colour_in=3'b101 at pos (10,20) -> 16 consecutive vga_plot cycles covering x 10..13 × y 20..23 in row-major order, colour 101. done pulses in the cycle after the last pixel. busy is high for 17 cycles.
- plot_en while busy, and pos_en while busy -> ignored: exactly 16 writes and position unchanged. pos_en and plot_en together in IDLE with dir_down -> the sprite is drawn at the new y.
- Reset asserted on the 5th DRAW cycle -> vga_plot=0 and busy=0 from the next cycle, no done pulse, pos=(78,58). With SPRITE_MASK_EN and mask 16'h8001 -> exactly 2 writes at (x0,y0) and (x0+3,y0+3), done still at cycle k+17.
